// File: rtl/instr_encoder.sv
// Instruction-word generator: turns Opsel requests into RV32 R/I-type words with sequential addresses.
// Optional INSTR_ENC_CHECK_EN adds a re-decode checker driving the sticky chk_fail output.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_imm,
    input  logic [3:0]        in_opsel,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [11:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done,
`ifdef INSTR_ENC_CHECK_EN
    output logic              chk_fail,
`endif
    output logic              err
);

    localparam logic [6:0]        OpcR      = 7'b0110011;
    localparam logic [6:0]        OpcI      = 7'b0010011;
    localparam logic [ADDR_W-1:0] LastAddr  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] BaseAddr  = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {StIdle, StEnc, StOut, StFull} state_e;

    state_e            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              req_load;

    logic              is_imm_q;
    logic [3:0]        opsel_q;
    logic [4:0]        rd_q, rs1_q, rs2_q;
    logic [11:0]       imm_q;

    logic [31:0]       word;
    logic              illegal;
    logic [9:0]        r_sel;

    // {funct7, funct3} for an R-type Opsel; mirrors the control-unit decode table.
    function automatic logic [9:0] r_funct(input logic [3:0] opsel);
        logic [9:0] f;
        f = '0;
        case (opsel)
            4'd0:  f = {7'd0, 3'd0};
            4'd1:  f = {7'd0, 3'd1};
            4'd2:  f = {7'd0, 3'd2};
            4'd3:  f = {7'd1, 3'd0};
            4'd4:  f = {7'd1, 3'd1};
            4'd5:  f = {7'd1, 3'd2};
            4'd6:  f = {7'd1, 3'd3};
            4'd7:  f = {7'd2, 3'd0};
            4'd8:  f = {7'd2, 3'd1};
            4'd9:  f = {7'd3, 3'd0};
            4'd10: f = {7'd3, 3'd1};
            4'd11: f = {7'd3, 3'd2};
            4'd12: f = {7'd3, 3'd3};
            4'd13: f = {7'd3, 3'd4};
            4'd14: f = {7'd5, 3'd4};
            4'd15: f = {7'd3, 3'd5};
            default: f = '0;
        endcase
        return f;
    endfunction

    always_comb begin
        r_sel   = r_funct(opsel_q);
        illegal = is_imm_q & opsel_q[3];
        if (is_imm_q) begin
            word = {imm_q, rs1_q, opsel_q[2:0], rd_q, OpcI};
        end else begin
            word = {r_sel[9:3], rs2_q, rs1_q, r_sel[2:0], rd_q, OpcR};
        end
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        addr_d   = addr_q;
        done_d   = done_q;
        err_d    = err_q;
        req_load = 1'b0;
        if (clear) begin
            state_d = StIdle;
            addr_d  = BaseAddr;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        req_load = 1'b1;
                        state_d  = StEnc;
                    end
                end
                StEnc: begin
                    if (illegal) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        instr_d = word;
                        state_d = StOut;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        if (addr_q == LastAddr) begin
                            done_d  = 1'b1;
                            state_d = StFull;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                StFull: state_d = StFull;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            instr_q <= '0;
            addr_q  <= BaseAddr;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_imm_q <= 1'b0;
            opsel_q  <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
        end else if (req_load) begin
            is_imm_q <= in_is_imm;
            opsel_q  <= in_opsel;
            rd_q     <= in_rd;
            rs1_q    <= in_rs1;
            rs2_q    <= in_rs2;
            imm_q    <= in_imm;
        end
    end

    // Ready is masked during reset/clear so no handshake is silently lost.
    assign in_ready  = (state_q == StIdle) & ~reset & ~clear;
    assign out_valid = (state_q == StOut);
    assign out_instr = instr_q;
    assign out_addr  = addr_q;
    assign done      = done_q;
    assign err       = err_q;

`ifdef INSTR_ENC_CHECK_EN
    logic       chk_q;
    logic       dec_ok;
    logic       dec_imm;
    logic [3:0] dec_opsel;
    logic [4:0] dec_r;
    logic       chk_mismatch;

    // Returns {known, opsel} for an R-type {funct7, funct3} pair.
    function automatic logic [4:0] decode_r(input logic [6:0] f7, input logic [2:0] f3);
        logic [4:0] d;
        d = '0;
        case ({f7, f3})
            {7'd0, 3'd0}: d = {1'b1, 4'd0};
            {7'd0, 3'd1}: d = {1'b1, 4'd1};
            {7'd0, 3'd2}: d = {1'b1, 4'd2};
            {7'd1, 3'd0}: d = {1'b1, 4'd3};
            {7'd1, 3'd1}: d = {1'b1, 4'd4};
            {7'd1, 3'd2}: d = {1'b1, 4'd5};
            {7'd1, 3'd3}: d = {1'b1, 4'd6};
            {7'd2, 3'd0}: d = {1'b1, 4'd7};
            {7'd2, 3'd1}: d = {1'b1, 4'd8};
            {7'd3, 3'd0}: d = {1'b1, 4'd9};
            {7'd3, 3'd1}: d = {1'b1, 4'd10};
            {7'd3, 3'd2}: d = {1'b1, 4'd11};
            {7'd3, 3'd3}: d = {1'b1, 4'd12};
            {7'd3, 3'd4}: d = {1'b1, 4'd13};
            {7'd5, 3'd4}: d = {1'b1, 4'd14};
            {7'd3, 3'd5}: d = {1'b1, 4'd15};
            default:      d = '0;
        endcase
        return d;
    endfunction

    always_comb begin
        dec_ok    = 1'b0;
        dec_imm   = 1'b0;
        dec_opsel = '0;
        dec_r     = decode_r(instr_q[31:25], instr_q[14:12]);
        case (instr_q[6:0])
            OpcR: begin
                dec_ok    = dec_r[4];
                dec_opsel = dec_r[3:0];
            end
            OpcI: begin
                dec_ok    = 1'b1;
                dec_imm   = 1'b1;
                dec_opsel = {1'b0, instr_q[14:12]};
            end
            default: dec_ok = 1'b0;
        endcase
        chk_mismatch = ~dec_ok | (dec_opsel != opsel_q) | (dec_imm != is_imm_q);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            chk_q <= 1'b0;
        end else if (out_valid && chk_mismatch) begin
            chk_q <= 1'b1;
        end
    end

    assign chk_fail = chk_q;
`endif

endmodule
